// File: rtl/iot_deser.sv
// iot_deser: byte-serial collector, builds 128-bit words (MSB byte first), eight words per group.
// Latency: a byte captured at edge N is in data[7:0] after edge N; valid pulses after the 128th capture.
// Backpressure: busy is high for BUSY_CYCLES after a group, and bytes offered then are dropped.
// Optional: `define IOT_DESER_TIMEOUT_EN discards a stalled partial group after TIMEOUT idle cycles (err pulse).
module iot_deser #(
  parameter int BUSY_CYCLES = 2
`ifdef IOT_DESER_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_en,
  input  logic [7:0]   iot_in,
  output logic         busy,
  output logic [127:0] data,
  output logic [3:0]   cnt_cycle,
  output logic [2:0]   cnt_data,
  output logic         valid,
  output logic         err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t         state_q;
  logic [127:0]   data_q;
  logic [3:0]     cyc_q;
  logic [2:0]     word_q;
  logic           busy_q;
  logic           valid_q;
  logic [3:0]     hold_q;
  logic           capture;
`ifdef IOT_DESER_TIMEOUT_EN
  logic [7:0]     idle_q;
  logic           err_q;
`endif

  // busy is registered, so capture never depends combinationally on anything but the inputs and state
  assign capture = in_en & ~busy_q;

  // Group FSM: owns the shift register, position counters and every registered strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cyc_q   <= '0;
      word_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      hold_q  <= '0;
`ifdef IOT_DESER_TIMEOUT_EN
      idle_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
`ifdef IOT_DESER_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (capture) begin
            // A new group starts from a clean word so stale bytes never leak in
            state_q <= S_COLLECT;
            data_q  <= {120'b0, iot_in};
            cyc_q   <= 4'd0;
            word_q  <= 3'd0;
`ifdef IOT_DESER_TIMEOUT_EN
            idle_q  <= '0;
`endif
          end
        end
        S_COLLECT: begin
          if (capture) begin
            data_q <= {data_q[119:0], iot_in};
`ifdef IOT_DESER_TIMEOUT_EN
            idle_q <= '0;
`endif
            if (cyc_q == 4'd15) begin
              // Word boundary: keep shifting, next word overwrites the old bytes naturally
              cyc_q  <= 4'd0;
              word_q <= word_q + 3'd1;
            end else begin
              cyc_q <= cyc_q + 4'd1;
              if (cyc_q == 4'd14 && word_q == 3'd7) begin
                // Last byte of the group lands now; strobe and throttle start together next cycle
                state_q <= S_HOLD;
                busy_q  <= 1'b1;
                valid_q <= 1'b1;
                hold_q  <= 4'(BUSY_CYCLES - 1);
              end
            end
          end
`ifdef IOT_DESER_TIMEOUT_EN
          else if (idle_q == 8'(TIMEOUT - 1)) begin
            // Stalled source: drop the partial group and flag it
            state_q <= S_IDLE;
            data_q  <= '0;
            cyc_q   <= 4'd0;
            word_q  <= 3'd0;
            idle_q  <= '0;
            err_q   <= 1'b1;
          end else begin
            idle_q <= idle_q + 8'd1;
          end
`endif
        end
        S_HOLD: begin
          // data and counters stay frozen so downstream can finish the group
          if (hold_q == 4'd0) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            hold_q <= hold_q - 4'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign data      = data_q;
  assign cnt_cycle = cyc_q;
  assign cnt_data  = word_q;
  assign valid     = valid_q;
`ifdef IOT_DESER_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_iot_deser.sv
module tb_iot_deser;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_en;
  logic [7:0]   iot_in;
  logic         busy;
  logic [127:0] data;
  logic [3:0]   cnt_cycle;
  logic [2:0]   cnt_data;
  logic         valid;
  logic         err;

  iot_deser #(.BUSY_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .iot_in(iot_in), .busy(busy),
    .data(data), .cnt_cycle(cnt_cycle), .cnt_data(cnt_data), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] w;
    logic [2:0]   idx;
  } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad = 0;
  logic [127:0] mcur = '0;
  int mcnt = 0;
  int first_cyc = 0;
  int gaps = 0;
  int exp_valid_cyc = -1;
  int valid_seen = 0;
  int busy_seen = 0;
  logic [127:0] last_word = '0;
  logic [3:0] pc = '0;
  logic [2:0] pd = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pop a scoreboard entry each time a new word completes; check valid timing/content.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      if (cnt_cycle == 4'd15 && (pc != 4'd15 || pd != cnt_data)) begin
        check("sb_has_entry", 128'(sbq.size() > 0), 128'd1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("word_data", data, e.w);
          check("word_idx", 128'(cnt_data), 128'(e.idx));
        end
      end
      if (valid) begin
        valid_seen++;
        check("valid_cyc", 128'(cyc), 128'(exp_valid_cyc));
        check("valid_idx", 128'(cnt_data), 128'd7);
        check("valid_data", data, last_word);
      end
      if (busy) busy_seen++;
    end
    pc = cnt_cycle;
    pd = cnt_data;
  end

  task automatic send(input logic [7:0] b);
    in_en = 1'b1;
    iot_in = b;
    @(posedge clk);
    #1;
    in_en = 1'b0;
    if (mcnt == 0) begin
      first_cyc = cyc;
      gaps = 0;
    end
    mcur = {mcur[119:0], b};
    mcnt++;
    if (mcnt % 16 == 0) sbq.push_back('{mcur, 3'(mcnt / 16 - 1)});
    if (mcnt == 128) begin
      last_word = mcur;
      exp_valid_cyc = first_cyc + 127 + gaps;
      mcnt = 0;
    end
  endtask

  task automatic idle(input int n);
    in_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (mcnt != 0) gaps++;
    end
  endtask

  task automatic group(input logic [7:0] base, input bit gapped);
    for (int i = 0; i < 128; i++) begin
      send(8'(base + 8'(i)));
      if (gapped && (i % 2 == 1) && i != 127) idle(1);
    end
  endtask

  task automatic check_hold_end(input string tag);
    check({tag, "_busy_cycles"}, 128'(busy_seen), 128'd2);
    check({tag, "_valid_count"}, 128'(valid_seen), 128'd1);
    check({tag, "_busy_low"}, 128'(busy), 128'd0);
    busy_seen = 0;
    valid_seen = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, data, 128'd0);
    check({tag, "_cnt_cycle"}, 128'(cnt_cycle), 128'd0);
    check({tag, "_cnt_data"}, 128'(cnt_data), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_valid"}, 128'(valid), 128'd0);
    check({tag, "_err"}, 128'(err), 128'd0);
  endtask

  initial begin
    rst = 1'b0;
    in_en = 1'b0;
    iot_in = 8'h00;
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Group 1: 0x00..0x7F back-to-back
    for (int i = 0; i < 16; i++) send(8'(i));
    check("word0_const", data, 128'h000102030405060708090a0b0c0d0e0f);
    check("word0_cnt_cycle", 128'(cnt_cycle), 128'd15);
    check("word0_cnt_data", 128'(cnt_data), 128'd0);
    for (int i = 16; i < 128; i++) send(8'(i));
    check("last_word_const", last_word, 128'h707172737475767778797a7b7c7d7e7f);
    idle(2);
    check_hold_end("g1");

    // Group 2: same stream, in_en low every third cycle
    group(8'h00, 1'b1);
    idle(2);
    check_hold_end("g2");

    // Group 3: in_en held high with 0xAA through HOLD
    group(8'h80, 1'b0);
    in_en = 1'b1;
    iot_in = 8'hAA;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("hold_frozen_data", data, last_word);
    check("hold_frozen_cyc", 128'(cnt_cycle), 128'd15);
    check("hold_frozen_word", 128'(cnt_data), 128'd7);
    check_hold_end("g3");
    send(8'h55);
    check("restart_data", data, 128'h55);
    check("restart_cnt_cycle", 128'(cnt_cycle), 128'd0);
    check("restart_cnt_data", 128'(cnt_data), 128'd0);
    for (int i = 1; i < 37; i++) send(8'(8'h55 + 8'(i)));
    check("mid_cnt_cycle", 128'(cnt_cycle), 128'd4);
    check("mid_cnt_data", 128'(cnt_data), 128'd2);

    // Asynchronous reset mid-word
    rst = 1'b0;
    #1;
    check_zero("midrst");
    check("midrst_sb_empty", 128'(sbq.size()), 128'd0);
    mcnt = 0;
    mcur = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    group(8'h10, 1'b0);
    idle(2);
    check_hold_end("g4");

`ifdef IOT_DESER_TIMEOUT_EN
    // Gap of 15 idle cycles then a capture: no timeout
    for (int i = 0; i < 20; i++) send(8'(8'hC0 + 8'(i)));
    idle(15);
    check("gap15_err", 128'(err), 128'd0);
    check("gap15_cnt_cycle", 128'(cnt_cycle), 128'd3);
    send(8'hD4);
    check("gap15_resume_cycle", 128'(cnt_cycle), 128'd4);
    check("gap15_resume_word", 128'(cnt_data), 128'd1);
    check("gap15_resume_err", 128'(err), 128'd0);
    // 16 idle cycles after the last capture: discard and err pulse
    idle(15);
    check("to_err_early", 128'(err), 128'd0);
    idle(1);
    check("to_err_pulse", 128'(err), 128'd1);
    check("to_data", data, 128'd0);
    check("to_cnt_cycle", 128'(cnt_cycle), 128'd0);
    check("to_cnt_data", 128'(cnt_data), 128'd0);
    check("to_busy", 128'(busy), 128'd0);
    mcnt = 0;
    mcur = '0;
    idle(1);
    check("to_err_once", 128'(err), 128'd0);
`else
    // Partial group then a long stall: no discard without the timeout feature
    for (int i = 0; i < 20; i++) send(8'(8'hC0 + 8'(i)));
    idle(40);
    check("stall_err_tied", 128'(err), 128'd0);
    check("stall_cnt_cycle", 128'(cnt_cycle), 128'd3);
    check("stall_cnt_data", 128'(cnt_data), 128'd1);
`endif

    check("final_sb_empty", 128'(sbq.size()), 128'd0);
    check("final_valid_total", 128'(valid_seen), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iot_deser.md
# iot_deser

Byte-serial input collector for the IoT data-filtering datapath. It assembles the 8-bit sensor stream into 128-bit words and groups them eight words at a time. It presents each word together with its position counters (`cnt_cycle`, `cnt_data`) and a group-complete `valid` strobe. It sits directly upstream of the filter function units (max/min/range stages), which sample `data` when `cnt_cycle` is 15. It throttles the source with `busy` while the downstream stages close a group.

## Interface
- `BUSY_CYCLES`, default 2: cycles `busy` stays high after a group completes; legal range 1..15.
- `TIMEOUT`, default 16: idle cycles before a partial group is discarded; legal range 2..255; used only with `IOT_DESER_TIMEOUT_EN`.
- `clk`  input  1: sole clock, rising edge.
- `rst`  input  1: asynchronous, active-low reset.
- `in_en`  input  1: `iot_in` holds a valid byte this cycle.
- `iot_in`  input  8: stream byte; first byte of a word is its MSB byte.
- `busy`  output  1: source must not present bytes; bytes offered while high are dropped.
- `data`  output  128: word under assembly; the full word is present when `cnt_cycle` is 15.
- `cnt_cycle`  output  4: index of the last captured byte within the current word, 0..15.
- `cnt_data`  output  3: index of the current word within its group, 0..7.
- `valid`  output  1: one-cycle pulse when word 7 of a group is complete.
- `err`  output  1: one-cycle pulse when a partial group is discarded by timeout.

## Operation
- States:
  - IDLE: no group in progress.
  - COLLECT: group in progress.
  - HOLD: group done, `busy` high.
- Capture condition: `in_en`=1 and `busy`=0 at a rising edge.
- Shift rule: `data` <= {`data`[119:0], `iot_in`}.
- IDLE + capture → COLLECT:
  - `cnt_cycle` = 0, `cnt_data` = 0.
  - `data` is cleared before the shift, so `data` = {120'b0, byte}.
- COLLECT + capture:
  - If `cnt_cycle` < 15: `cnt_cycle` increments.
  - If `cnt_cycle` = 15 and `cnt_data` < 7: `cnt_cycle` wraps to 0, `cnt_data` increments, and the shift continues (no clear).
- Capture that makes `cnt_cycle`=15 with `cnt_data`=7 → HOLD. `valid` pulses on the first cycle those registered values are visible.
- HOLD:
  - `busy`=1 for exactly `BUSY_CYCLES` cycles, starting in the `valid` cycle.
  - `data`, `cnt_cycle` and `cnt_data` are frozen.
  - Then → IDLE.
- Counters and `data` hold whenever no capture occurs. Gaps in `in_en` are legal at any byte position.
- Outputs are registered. `busy`, `valid` and `err` are decoded from registered state only, with no combinational path from `in_en` or `iot_in`.

## Timing
- Reset values: `data`=0, `cnt_cycle`=0, `cnt_data`=0, `busy`=0, `valid`=0, `err`=0, state IDLE.
- Asserting `rst` mid-word or during HOLD clears everything immediately. The first capture after release starts a new group.
- Latency: a byte captured at edge N is visible in `data`[7:0] after edge N.
- Full group: 128 back-to-back captures. `valid` is high during cycle 128 after the first capture edge.
- Next group: earliest capture is on the edge ending the last `busy` cycle's successor, i.e. `BUSY_CYCLES` dead cycles.
- `in_en`=1 during HOLD: the byte is ignored and no counter moves.

## Configuration
- `IOT_DESER_TIMEOUT_EN` defined:
  - In COLLECT, an idle counter increments each cycle with no capture and clears on each capture.
  - When it reaches `TIMEOUT`: state → IDLE, `data`/`cnt_cycle`/`cnt_data` → 0, `err` pulses one cycle, and `busy` stays 0.
  - A capture on the same edge the counter would reach `TIMEOUT` wins; no timeout occurs.
- Undefined: there is no idle counter, COLLECT waits indefinitely, and `err` is tied to 0.

## Test plan
- Reset, then 128 bytes 0x00..0x7F back-to-back:
  - Word 0 = 0x000102…0F, seen when `cnt_cycle`=15 and `cnt_data`=0.
  - `valid`=1 exactly once, with `cnt_data`=7 and `data`=0x707172…7F.
  - `busy`=1 for 2 cycles.
- Same stream with `in_en` low every third cycle: identical words and counters; `valid` delayed by the gap count.
- `in_en` held high through HOLD with byte 0xAA: no capture. The next group's word 0 starts with the byte offered after `busy` falls.
- Assert `rst` after 37 bytes: all outputs 0 immediately; a fresh 128-byte group completes normally.
- Timeout enabled, `TIMEOUT`=16, 20 bytes then `in_en` low: `err` pulses 16 cycles after the last capture; counters and `data` go to 0.
- Timeout enabled, gap of 15 cycles, then capture: no `err`, and collection continues with `cnt_cycle`=4 and `cnt_data`=1 after the 21st byte.
